// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetch / execute / memory / writeback with a shared
// memory bus, bus-timeout fault detection, debug-dump handshake and saturating counters.
module cpu_sequencer #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dMemLoad,
    input  logic        dMemStore,
    input  logic        dJmpEn,
    input  logic        dRdWE,
    input  logic        dHalt,
    input  logic        dDebugDump,
    input  logic        jmpTaken,
    output logic        busReq,
    output logic        busWe,
    output logic        busAddrSel,
    input  logic        busAck,
    output logic        iRegWE,
    output logic        memDataWE,
    output logic        pcWE,
    output logic        pcSel,
    output logic        rfWE,
    output logic        rfSrcMem,
    output logic        dumpReq,
    input  logic        dumpDone,
    output logic        halted,
    output logic        fault,
    output logic [2:0]  state,
    output logic [31:0] cycleCount,
    output logic [31:0] instret
);
    localparam int WAIT_W = $clog2(BUS_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = BUS_TIMEOUT[WAIT_W-1:0];

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_EXEC  = 3'd1,
        S_MEM   = 3'd2,
        S_WB    = 3'd3,
        S_DUMP  = 3'd4,
        S_HALT  = 3'd5,
        S_FAULT = 3'd6,
        S_BAD   = 3'd7
    } state_t;

    state_t            st;
    logic [WAIT_W-1:0] wait_cnt;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Wait counter is zero whenever the FSM is outside a bus state, so every
    // entry into FETCH or MEM starts counting from zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st         <= S_FETCH;
            wait_cnt   <= '0;
            cycleCount <= '0;
            instret    <= '0;
        end else begin
            if (st != S_HALT && st != S_FAULT)
                cycleCount <= sat_inc(cycleCount);
            wait_cnt <= '0;
            case (st)
                S_FETCH, S_MEM: begin
                    if (busAck)
                        st <= (st == S_FETCH) ? S_EXEC : S_WB;
                    else if (wait_cnt == WAIT_MAX)
                        st <= S_FAULT;
                    else
                        wait_cnt <= wait_cnt + 1'b1;
                end
                S_EXEC: begin
                    if (dHalt) begin
                        st      <= S_HALT;
                        instret <= sat_inc(instret);
                    end else if (dDebugDump)
                        st <= S_DUMP;
                    else if (dMemLoad || dMemStore)
                        st <= S_MEM;
                    else
                        st <= S_WB;
                end
                S_DUMP: if (dumpDone) st <= S_WB;
                S_WB: begin
                    st      <= S_FETCH;
                    instret <= sat_inc(instret);
                end
                S_HALT:  st <= S_HALT;
                S_FAULT: st <= S_FAULT;
                default: st <= S_FETCH;
            endcase
        end
    end

    // Enables are gated by rst_n so an asserted reset aborts bus traffic immediately.
    always_comb begin
        busReq     = 1'b0;
        busWe      = 1'b0;
        busAddrSel = 1'b0;
        iRegWE     = 1'b0;
        memDataWE  = 1'b0;
        pcWE       = 1'b0;
        pcSel      = 1'b0;
        rfWE       = 1'b0;
        rfSrcMem   = 1'b0;
        dumpReq    = 1'b0;
        halted     = 1'b0;
        fault      = 1'b0;
        case (st)
            S_FETCH: begin
                busReq = rst_n;
                iRegWE = rst_n && busAck;
            end
            S_MEM: begin
                busReq     = rst_n;
                busWe      = rst_n && dMemStore;
                busAddrSel = 1'b1;
                memDataWE  = rst_n && busAck && dMemLoad && !dMemStore;
            end
            S_WB: begin
                pcWE     = rst_n;
                pcSel    = dJmpEn && jmpTaken;
                rfWE     = rst_n && dRdWE;
                rfSrcMem = dMemLoad;
            end
            S_DUMP:  dumpReq = rst_n;
            S_HALT:  halted  = 1'b1;
            S_FAULT: fault   = 1'b1;
            default: ;
        endcase
    end

    assign state = st;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: an instruction-level model expands each instruction
// into its expected cycle schedule; a monitor compares every cycle against that schedule.
`timescale 1ns/1ps
module tb_cpu_sequencer;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dMemLoad = 0, dMemStore = 0, dJmpEn = 0, dRdWE = 0, dHalt = 0, dDebugDump = 0;
    logic        jmpTaken = 0, busAck = 0, dumpDone = 0;
    logic        busReq, busWe, busAddrSel, iRegWE, memDataWE, pcWE, pcSel, rfWE, rfSrcMem;
    logic        dumpReq, halted, fault;
    logic [2:0]  state;
    logic [31:0] cycleCount, instret;

    always #5 clk = ~clk;

    cpu_sequencer #(.BUS_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .dMemLoad(dMemLoad), .dMemStore(dMemStore), .dJmpEn(dJmpEn), .dRdWE(dRdWE),
        .dHalt(dHalt), .dDebugDump(dDebugDump), .jmpTaken(jmpTaken),
        .busReq(busReq), .busWe(busWe), .busAddrSel(busAddrSel), .busAck(busAck),
        .iRegWE(iRegWE), .memDataWE(memDataWE), .pcWE(pcWE), .pcSel(pcSel),
        .rfWE(rfWE), .rfSrcMem(rfSrcMem), .dumpReq(dumpReq), .dumpDone(dumpDone),
        .halted(halted), .fault(fault), .state(state),
        .cycleCount(cycleCount), .instret(instret)
    );

    typedef struct {
        logic [2:0]  st;
        logic        breq, bwe, bsel, irwe, mdwe, pcwe, pcsel, rfwe, rfsrc, dreq, hlt, flt;
        logic [31:0] cyc, ret;
    } exp_t;

    exp_t        q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int unsigned m_cyc = 0;
    int unsigned m_ret = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    endtask

    // Monitor: every cycle that has a scheduled expectation is compared mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk32("state", 32'(state), 32'(e.st));
                chk1("busReq", busReq, e.breq);
                chk1("busWe", busWe, e.bwe);
                chk1("busAddrSel", busAddrSel, e.bsel);
                chk1("iRegWE", iRegWE, e.irwe);
                chk1("memDataWE", memDataWE, e.mdwe);
                chk1("pcWE", pcWE, e.pcwe);
                chk1("pcSel", pcSel, e.pcsel);
                chk1("rfWE", rfWE, e.rfwe);
                chk1("rfSrcMem", rfSrcMem, e.rfsrc);
                chk1("dumpReq", dumpReq, e.dreq);
                chk1("halted", halted, e.hlt);
                chk1("fault", fault, e.flt);
                chk32("cycleCount", cycleCount, e.cyc);
                chk32("instret", instret, e.ret);
            end
        end
    end

    function automatic exp_t blank(input logic [2:0] s);
        exp_t e;
        e.st = s;   e.breq = 0; e.bwe = 0;  e.bsel = 0;  e.irwe = 0; e.mdwe = 0;
        e.pcwe = 0; e.pcsel = 0; e.rfwe = 0; e.rfsrc = 0; e.dreq = 0; e.hlt = 0;
        e.flt = 0;  e.cyc = 0;  e.ret = 0;
        return e;
    endfunction

    task automatic tick(input exp_t e, input bit counted);
        e.cyc = m_cyc;
        e.ret = m_ret;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (counted) m_cyc++;
    endtask

    task automatic rnd_dec();
        dMemLoad   = 1'($urandom_range(0, 1));
        dMemStore  = 1'($urandom_range(0, 1));
        dJmpEn     = 1'($urandom_range(0, 1));
        dRdWE      = 1'($urandom_range(0, 1));
        dHalt      = 1'($urandom_range(0, 1));
        dDebugDump = 1'($urandom_range(0, 1));
    endtask

    task automatic rnd_misc();
        busAck   = 1'($urandom_range(0, 1));
        dumpDone = 1'($urandom_range(0, 1));
        jmpTaken = 1'($urandom_range(0, 1));
    endtask

    task automatic reset_cycle(input logic [2:0] s);
        exp_t e;
        rst_n   = 1'b0;
        e       = blank(s);
        e.bsel  = (s == 3'd2);
        e.pcsel = (s == 3'd3) && dJmpEn && jmpTaken;
        e.rfsrc = (s == 3'd3) && dMemLoad;
        e.hlt   = (s == 3'd5);
        e.flt   = (s == 3'd6);
        tick(e, 0);
        rst_n = 1'b1;
        m_cyc = 0;
        m_ret = 0;
    endtask

    // HALT/FAULT: frozen for a few cycles regardless of inputs, then released by reset.
    task automatic terminal(input logic [2:0] s);
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            rnd_dec();
            rnd_misc();
            e     = blank(s);
            e.hlt = (s == 3'd5);
            e.flt = (s == 3'd6);
            tick(e, 0);
        end
        rnd_misc();
        reset_cycle(s);
    endtask

    // One instruction: fd/md = wait cycles before the fetch/data (or dump) handshake;
    // a wait beyond TMO faults; rst_at >= 0 asserts reset in that MEM wait cycle.
    task automatic do_instr(input bit ld, sto, jmp, jt, rdwe, hlt, dmp,
                            input int fd, md, rst_at);
        exp_t e;
        for (int i = 0; i <= TMO; i++) begin
            rnd_dec();
            rnd_misc();
            busAck = (i == fd);
            e      = blank(3'd0);
            e.breq = 1'b1;
            e.irwe = (i == fd);
            tick(e, 1);
            if (i == fd) break;
            if (i == TMO) begin
                terminal(3'd6);
                return;
            end
        end
        dMemLoad = ld; dMemStore = sto; dJmpEn = jmp; dRdWE = rdwe; dHalt = hlt; dDebugDump = dmp;
        rnd_misc();
        tick(blank(3'd1), 1);
        if (hlt) begin
            m_ret++;
            terminal(3'd5);
            return;
        end
        if (dmp) begin
            for (int i = 0; i <= md; i++) begin
                rnd_misc();
                dumpDone = (i == md);
                e        = blank(3'd4);
                e.dreq   = 1'b1;
                tick(e, 1);
            end
        end else if (ld || sto) begin
            for (int i = 0; i <= TMO; i++) begin
                rnd_misc();
                busAck = (i == md);
                if (i == rst_at) begin
                    reset_cycle(3'd2);
                    return;
                end
                e      = blank(3'd2);
                e.breq = 1'b1;
                e.bwe  = sto;
                e.bsel = 1'b1;
                e.mdwe = (i == md) && ld && !sto;
                tick(e, 1);
                if (i == md) break;
                if (i == TMO) begin
                    terminal(3'd6);
                    return;
                end
            end
        end
        rnd_misc();
        jmpTaken = jt;
        e        = blank(3'd3);
        e.pcwe   = 1'b1;
        e.pcsel  = jmp && jt;
        e.rfwe   = rdwe;
        e.rfsrc  = ld;
        tick(e, 1);
        m_ret++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        reset_cycle(3'd0);

        // ALU loop with zero-wait bus
        for (int i = 0; i < 10; i++) do_instr(0, 0, 0, 0, 1, 0, 0, 0, 0, -1);
        chk32("alu_loop_cycles", cycleCount, 32'd30);
        chk32("alu_loop_instret", instret, 32'd10);

        // load with delayed acks, taken/not-taken branches
        do_instr(1, 0, 0, 0, 1, 0, 0, 2, 1, -1);
        do_instr(0, 0, 1, 1, 0, 0, 0, 0, 0, -1);
        do_instr(0, 0, 1, 0, 0, 0, 0, 1, 0, -1);
        do_instr(1, 1, 0, 0, 1, 0, 0, 0, 2, -1);

        // dump for 5 cycles, then halt beats dump
        do_instr(0, 0, 0, 0, 0, 0, 1, 0, 4, -1);
        do_instr(0, 0, 0, 0, 0, 1, 1, 0, 0, -1);

        // fetch timeout boundary: ack on the last allowed cycle, then one past it
        do_instr(0, 0, 0, 0, 1, 0, 0, TMO, 0, -1);
        do_instr(0, 0, 0, 0, 1, 0, 0, TMO + 1, 0, -1);
        do_instr(1, 0, 0, 0, 1, 0, 0, 0, TMO, -1);
        do_instr(0, 1, 0, 0, 0, 0, 0, 0, TMO + 1, -1);

        // reset during a store wait
        do_instr(0, 1, 0, 0, 0, 0, 0, 0, 3, 1);
        do_instr(0, 0, 0, 0, 1, 0, 0, 0, 0, -1);

        for (int n = 0; n < 150; n++) begin
            bit ld, sto, jmp, jt, rdwe, hlt, dmp;
            int fd, md, ra;
            ld   = ($urandom_range(0, 3) == 0);
            sto  = ($urandom_range(0, 3) == 0);
            jmp  = 1'($urandom_range(0, 1));
            jt   = 1'($urandom_range(0, 1));
            rdwe = 1'($urandom_range(0, 1));
            hlt  = ($urandom_range(0, 24) == 0);
            dmp  = ($urandom_range(0, 9) == 0);
            fd   = ($urandom_range(0, 29) == 0) ? TMO + 1 : int'($urandom_range(0, TMO));
            md   = ($urandom_range(0, 29) == 0) ? TMO + 1 : int'($urandom_range(0, TMO));
            ra   = ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, 2)) : -1;
            do_instr(ld, sto, jmp, jt, rdwe, hlt, dmp, fd, md, ra);
        end

        @(posedge clk);
        #1;
        chk32("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control FSM for the CPU core. It sequences each instruction through fetch, execute, memory and writeback, and shares the single memory bus between instruction fetch and data load/store. It consumes the decoder's control outputs and drives the enables for the instruction register, PC, register file and memory bus. It also keeps cycle and retired-instruction counters.

## Interface
Parameters:
- BUS_TIMEOUT, default 255: maximum number of cycles to wait for busAck before entering FAULT; must be ≥1.

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- rst_n, in, 1: reset, synchronous, active-low.
- dMemLoad, dMemStore, dJmpEn, dRdWE, dHalt, dDebugDump, in, 1 each: decoder outputs for the instruction currently in the IR.
- jmpTaken, in, 1: branch-condition result; valid in WB.
- busReq, out, 1: memory bus request.
- busWe, out, 1: write strobe, qualified by busReq.
- busAddrSel, out, 1: address source; 0 = PC, 1 = ALU result.
- busAck, in, 1: transaction completes in any cycle where busReq && busAck.
- iRegWE, out, 1: load the IR from bus read data.
- memDataWE, out, 1: load the load-data register from bus read data.
- pcWE, out, 1: update the PC.
- pcSel, out, 1: next-PC source; 0 = PC+4, 1 = jump target.
- rfWE, out, 1: register-file write enable.
- rfSrcMem, out, 1: register-file write data source; 1 = load-data register, 0 = ALU.
- dumpReq, out, 1: debug-dump request.
- dumpDone, in, 1: debug-dump completion.
- halted, out, 1: core is halted.
- fault, out, 1: core is faulted.
- state, out, 3: current FSM state.
- cycleCount, out, 32: cycle counter.
- instret, out, 32: retired-instruction counter.

## Operation
State encoding: FETCH=0, EXEC=1, MEM=2, WB=3, DUMP=4, HALT=5, FAULT=6. Code 7 is unreachable and recovers to FETCH on the next edge.

- **FETCH:**
  - Drives busReq=1, busWe=0, busAddrSel=0.
  - On busAck: iRegWE=1 for that cycle, then go to EXEC.
- **EXEC:** one cycle; decoder inputs are stable. Next-state priority:
  - dHalt → HALT; instret increments; PC not advanced.
  - else dDebugDump → DUMP.
  - else dMemLoad or dMemStore → MEM.
  - else → WB.
- **MEM:**
  - Drives busReq=1, busAddrSel=1, busWe=dMemStore. If both dMemLoad and dMemStore are set, the access is a store.
  - On busAck: memDataWE = dMemLoad && !dMemStore, then go to WB.
- **WB:** one cycle.
  - pcWE=1; pcSel = dJmpEn && jmpTaken.
  - rfWE = dRdWE; rfSrcMem = dMemLoad.
  - instret increments; next state FETCH.
- **DUMP:** holds dumpReq=1 until dumpDone, then goes to WB (PC advances; rfWE follows dRdWE, which is 0 for dump).
- **HALT:** terminal until reset. halted=1; all enables and busReq are 0.
- **FAULT:** terminal until reset. fault=1; all enables and busReq are 0.

Bus timeout:
- Wait counter, width clog2(BUS_TIMEOUT+1), is cleared on entry to FETCH or MEM and increments each cycle without busAck.
- When the counter equals BUS_TIMEOUT and busAck=0, the next state is FAULT.
- busAck in that same cycle wins; the transaction completes normally.

Counters:
- cycleCount increments every cycle when rst_n=1 and the state is not HALT or FAULT.
- instret increments as listed above.
- Both saturate at 32'hFFFF_FFFF; no wrap.

Outputs:
- All outputs are combinational from the state register and the inputs.
- While rst_n=0, busReq, busWe, iRegWE, memDataWE, pcWE, rfWE and dumpReq are forced to 0.

## Timing
Reset:
- An edge with rst_n=0 sets state=FETCH, clears the wait counter, and sets cycleCount=0 and instret=0.
- Reset values of the remaining outputs: busAddrSel=0, pcSel=0, rfSrcMem=0, halted=0, fault=0, state=0.
- busReq rises in the first cycle with rst_n=1.
- Reset asserted in any state, including mid-transaction, HALT or FAULT, aborts immediately: the bus request drops in the same cycle and no enables fire.

Latency and handshakes:
- Zero-wait bus, where busAck is high in the same cycle as busReq:
  - ALU or branch instruction: 3 cycles (FETCH, EXEC, WB).
  - Load or store: 4 cycles.
  - Each bus wait cycle adds 1.
- busReq stays high until busAck is seen. busAck while busReq=0 is ignored.
- dumpDone while not in DUMP is ignored.
- DUMP has no timeout.

## Test plan
- **ALU loop:** busAck always 1; instruction with dRdWE=1, all other decoder inputs 0.
  - → states cycle 0,1,3; rfWE=1 and pcWE=1 once every 3 cycles.
  - → after 30 cycles, instret=10 and cycleCount=30.
- **Load, fetch ack delayed 2 cycles:** dMemLoad=1, dRdWE=1; data-phase ack delayed 1 cycle.
  - → memDataWE pulses once; rfWE=1 with rfSrcMem=1 in WB.
  - → 7 cycles from FETCH entry to return to FETCH.
- **Branch:** dJmpEn=1.
  - jmpTaken=1 → pcSel=1 with pcWE in WB.
  - jmpTaken=0 → pcSel=0.
  - rfWE=0 in both cases.
- **Halt/dump priority:** dHalt=1 and dDebugDump=1 together → HALT after EXEC, halted=1, instret+1, cycleCount frozen.
  - dDebugDump alone with dumpDone after 5 cycles → dumpReq high for 5 cycles, then WB.
- **Timeout:** BUS_TIMEOUT=4, busAck stuck at 0 in FETCH → fault=1 on the 5th edge after FETCH entry.
  - Repeat with busAck=1 on the counter==4 cycle → no fault; goes to EXEC.
- **Reset mid-MEM:** rst_n=0 for 1 cycle during a store wait → busReq and busWe go 0 in that cycle; state=0 and counters=0 after the edge; busReq=1 in the next cycle.
